// File: rtl/ula_seq.sv
// ula_seq -- sequential ALU with single-cycle logic/arithmetic ops and
// iterative multiply / divide.
//
// Purpose
//   A request (start=1 while idle) samples sel/a/b. Most opcodes complete
//   on the sampling edge and pulse done in the following cycle. MUL (and
//   DIVU/REMU when the divider is built) run WIDTH iterations, one per
//   cycle, and pulse done WIDTH+1 cycles after the sampling edge.
//
// Configuration macro
//   ULA_SEQ_DIV_EN : when defined, DIVU (1101) / REMU (1110) use an
//                    iterative restoring divider. When undefined, those
//                    opcodes are single-cycle and return out=0, zero=1.
//
// Ports
//   clk     in   1      clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      operation request, honoured only when busy=0
//   sel     in   4      opcode
//   a, b    in   WIDTH  operands (signed for SLT / arithmetic shift)
//   busy    out  1      iterative operation in progress
//   done    out  1      one-cycle completion pulse
//   out     out  WIDTH  registered result
//   branch  out  1      registered branch decision (BEQ/BNE)
//   zero    out  1      registered "out written as all zeros" flag

module ula_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             branch,
  output logic             zero
);

  localparam logic [3:0] OP_ZERO = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_LI   = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
`ifdef ULA_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;
`endif
  localparam logic [3:0] OP_SRA  = 4'b1111;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

`ifdef ULA_SEQ_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL} state_t;
`endif

  state_t           state;
  logic [SHW-1:0]   cnt;
  // opa: multiplicand (shifts left) or dividend/quotient (shifts left)
  // opb: multiplier (shifts right) or divisor (static)
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
`ifdef ULA_SEQ_DIV_EN
  logic [WIDTH-1:0] rem;
  logic             rem_op;
`endif

  // Single-cycle result path
  logic [WIDTH-1:0] alu_res;
  logic             alu_br;
  logic             alu_keep;   // BEQ/BNE leave out/zero untouched
  logic [SHW-1:0]   shamt;

  assign shamt = b[SHW-1:0];

  always_comb begin
    alu_res  = '0;
    alu_br   = 1'b0;
    alu_keep = 1'b0;
    case (sel)
      OP_ZERO: alu_res = '0;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_NOT:  alu_res = ~a;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_LI:   alu_res = b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_BEQ:  begin alu_keep = 1'b1; alu_br = (a == b); end
      OP_BNE:  begin alu_keep = 1'b1; alu_br = (a != b); end
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;   // MUL is iterative; DIVU/REMU give 0 when not built
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  logic [WIDTH-1:0] mul_acc_next;
  assign mul_acc_next = opb[0] ? (acc + opa) : acc;

`ifdef ULA_SEQ_DIV_EN
  // One restoring-division step. The partial remainder is shifted left by
  // the next dividend bit; bit WIDTH of the trial difference is the borrow.
  // A zero divisor never borrows, so the quotient fills with ones and the
  // remainder ends up equal to the dividend.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign rem_sh   = {rem, opa[WIDTH-1]};
  assign div_sub  = rem_sh - {1'b0, opb};
  assign div_ge   = ~div_sub[WIDTH];
  assign rem_next = div_ge ? div_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_next = {opa[WIDTH-2:0], div_ge};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
`ifdef ULA_SEQ_DIV_EN
      rem    <= '0;
      rem_op <= 1'b0;
`endif
      busy   <= 1'b0;
      done   <= 1'b0;
      out    <= '0;
      branch <= 1'b0;
      zero   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (sel)
              OP_MUL: begin
                state <= MUL;
                busy  <= 1'b1;
                cnt   <= '0;
                acc   <= '0;
                opa   <= a;
                opb   <= b;
              end
`ifdef ULA_SEQ_DIV_EN
              OP_DIVU, OP_REMU: begin
                state  <= DIV;
                busy   <= 1'b1;
                cnt    <= '0;
                rem    <= '0;
                opa    <= a;
                opb    <= b;
                rem_op <= (sel == OP_REMU);
              end
`endif
              default: begin
                done   <= 1'b1;
                branch <= alu_br;
                if (!alu_keep) begin
                  out  <= alu_res;
                  zero <= (alu_res == '0);
                end
              end
            endcase
          end
        end

        MUL: begin
          acc <= mul_acc_next;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + SHW'(1);
          if (cnt == LAST_ITER) begin
            // Final iteration writes the result directly.
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            out    <= mul_acc_next;
            zero   <= (mul_acc_next == '0);
            branch <= 1'b0;
          end
        end

`ifdef ULA_SEQ_DIV_EN
        DIV: begin
          rem <= rem_next;
          opa <= quo_next;
          cnt <= cnt + SHW'(1);
          if (cnt == LAST_ITER) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            out    <= rem_op ? rem_next : quo_next;
            zero   <= ((rem_op ? rem_next : quo_next) == '0);
            branch <= 1'b0;
          end
        end
`endif

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq -- self-checking bench for ula_seq.
// A WIDTH=32 instance runs a table of single-cycle vectors followed by
// hand-written multi-cycle sequences (MUL, optional DIV, back-to-back
// start, reset mid-iteration). A WIDTH=8 instance covers the narrow case.

module tb_ula_seq;

  logic        clk;
  logic        rst_n;

  logic        start;
  logic [3:0]  sel;
  logic [31:0] a, b;
  logic        busy, done, branch, zero;
  logic [31:0] out;

  logic        s8_start;
  logic [3:0]  s8_sel;
  logic [7:0]  s8_a, s8_b;
  logic        s8_busy, s8_done, s8_branch, s8_zero;
  logic [7:0]  s8_out;

  int n_checks = 0;
  int n_fail   = 0;

  ula_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .branch(branch), .zero(zero)
  );

  ula_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .sel(s8_sel), .a(s8_a), .b(s8_b),
    .busy(s8_busy), .done(s8_done), .out(s8_out), .branch(s8_branch), .zero(s8_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        hold;     // out/zero keep their previous values
    logic [31:0] exp_out;
    logic        exp_br;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] s, input logic [31:0] va, input logic [31:0] vb,
                     input logic h, input logic [31:0] eo, input logic eb);
    vec_t v;
    v.sel = s; v.a = va; v.b = vb; v.hold = h; v.exp_out = eo; v.exp_br = eb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drives the request, returns at the next negedge
  // (the cycle after the sampling edge).
  task automatic fire(input logic [3:0] s, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1; sel = s; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Iterative op. Returns positioned in the done cycle (at its negedge).
  // When scramble is set the inputs (and start) are randomised while busy.
  task automatic run_iter(input string name, input logic [3:0] s,
                          input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] exp, input bit b2b, input bit scramble);
    int busy_cnt = 0;
    int done_cyc = 0;
    if (!b2b) @(negedge clk);
    fire(s, va, vb);
    for (int c = 1; c <= 45 && done_cyc == 0; c++) begin
      if (done) begin
        done_cyc = c;
        start = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (scramble) begin
          a = $urandom; b = $urandom; sel = 4'($urandom); start = 1'($urandom);
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    $display("iter %s sel=%b a=0x%0h b=0x%0h -> out=0x%0h done_cycle=%0d busy_cycles=%0d",
             name, s, va, vb, out, done_cyc, busy_cnt);
    chk({name, " done cycle"}, done_cyc, 33);
    chk({name, " busy cycles"}, busy_cnt, 32);
    chk({name, " busy in done"}, busy, 0);
    chk({name, " out"}, out, exp);
    chk({name, " zero"}, zero, (exp == 32'd0));
    chk({name, " branch"}, branch, 0);
  endtask

  logic [31:0] prev_out;
  logic        prev_zero;
  logic [31:0] e_out;
  logic        e_zero;
  int          seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = '0; a = '0; b = '0;
    s8_start = 1'b0; s8_sel = '0; s8_a = '0; s8_b = '0;

    add(4'b0001, 32'd7,        32'hFFFF_FFFD, 0, 32'd4,         0);
    add(4'b0001, 32'hFFFF_FFFF, 32'd2,        0, 32'd1,         0);
    add(4'b0010, 32'd5,        32'd5,         0, 32'd0,         0);
    add(4'b0010, 32'd3,        32'd5,         0, 32'hFFFF_FFFE, 0);
    add(4'b0011, 32'h0F0F_0F0F, 32'd0,        0, 32'hF0F0_F0F0, 0);
    add(4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 0, 32'h0000_F000, 0);
    add(4'b0101, 32'h0000_F0F0, 32'h0000_0F00, 0, 32'h0000_FFF0, 0);
    add(4'b0110, 32'd1,        32'h21,        0, 32'd2,         0);
    add(4'b0111, 32'h8000_0000, 32'd31,       0, 32'd1,         0);
    add(4'b1000, 32'hDEAD,     32'h1234,      0, 32'h1234,      0);
    add(4'b1001, 32'hFFFF_FFFF, 32'd1,        0, 32'd1,         0);
    add(4'b1010, 32'd5,        32'd5,         1, 32'd0,         1);
    add(4'b1011, 32'd5,        32'd5,         1, 32'd0,         0);
    add(4'b1011, 32'd5,        32'd6,         1, 32'd0,         1);
    add(4'b1001, 32'd1,        32'hFFFF_FFFF, 0, 32'd0,         0);
    add(4'b1010, 32'd7,        32'd8,         1, 32'd0,         0);
    add(4'b1111, 32'h8000_0000, 32'd4,        0, 32'hF800_0000, 0);
`ifndef ULA_SEQ_DIV_EN
    add(4'b1101, 32'd100,      32'd7,         0, 32'd0,         0);
    add(4'b1000, 32'd0,        32'd5,         0, 32'd5,         0);
    add(4'b1110, 32'd100,      32'd7,         0, 32'd0,         0);
`endif
    add(4'b1111, 32'h4000_0000, 32'h24,       0, 32'h0400_0000, 0);
    add(4'b0000, 32'hFFFF,     32'd1,         0, 32'd0,         0);

    // Reset state
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset out", out, 0);
    chk("reset branch", branch, 0);
    chk("reset zero", zero, 1);
    chk("reset8 zero", s8_zero, 1);
    @(negedge clk);
    rst_n = 1'b1;
    // First start is driven now and sampled on the first rising edge after release.

    prev_out = 32'd0; prev_zero = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      fire(vecs[i].sel, vecs[i].a, vecs[i].b);
      e_out  = vecs[i].hold ? prev_out  : vecs[i].exp_out;
      e_zero = vecs[i].hold ? prev_zero : (vecs[i].exp_out == 32'd0);
      $display("vec %0d sel=%b a=0x%0h b=0x%0h -> out=0x%0h br=%0b z=%0b done=%0b",
               i, vecs[i].sel, vecs[i].a, vecs[i].b, out, branch, zero, done);
      chk($sformatf("vec%0d done", i), done, 1);
      chk($sformatf("vec%0d busy", i), busy, 0);
      chk($sformatf("vec%0d out", i), out, e_out);
      chk($sformatf("vec%0d branch", i), branch, vecs[i].exp_br);
      chk($sformatf("vec%0d zero", i), zero, e_zero);
      prev_out = e_out; prev_zero = e_zero;
      @(negedge clk);
      chk($sformatf("vec%0d done pulse end", i), done, 0);
      chk($sformatf("vec%0d out held", i), out, e_out);
    end

    // MUL with operands/start scrambled while busy: 2^16 * 2^16 wraps to 0.
    run_iter("mul_wrap", 4'b1100, 32'h0001_0000, 32'h0001_0000, 32'd0, 0, 1);
    // Back-to-back MUL started in the done cycle.
    run_iter("mul_b2b", 4'b1100, 32'd123, 32'd456, 32'd56088, 1, 0);
    // Single-cycle op started in the done cycle.
    fire(4'b0001, 32'd10, 32'd20);
    $display("b2b add -> out=0x%0h done=%0b", out, done);
    chk("b2b add done", done, 1);
    chk("b2b add out", out, 32'd30);
    run_iter("mul_big", 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 0);

`ifdef ULA_SEQ_DIV_EN
    run_iter("divu", 4'b1101, 32'd100, 32'd7, 32'd14, 0, 0);
    run_iter("remu", 4'b1110, 32'd100, 32'd7, 32'd2, 0, 0);
    run_iter("divu_by0", 4'b1101, 32'd100, 32'd0, 32'hFFFF_FFFF, 0, 0);
    run_iter("remu_by0", 4'b1110, 32'h1234, 32'd0, 32'h1234, 0, 0);
    run_iter("divu_big", 4'b1101, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 1, 0);
`endif

    // Reset during MUL iteration 10 (out was nonzero before).
    run_iter("mul_pre", 4'b1100, 32'd6, 32'd7, 32'd42, 0, 0);
    @(negedge clk);
    fire(4'b1100, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    chk("mid busy before reset", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    $display("reset mid-mul -> busy=%0b out=0x%0h done=%0b", busy, out, done);
    chk("mid reset busy", busy, 0);
    chk("mid reset out", out, 0);
    chk("mid reset done", done, 0);
    chk("mid reset zero", zero, 1);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no done after abandoned op", seen, 0);
    run_iter("mul_after_reset", 4'b1100, 32'd3, 32'd5, 32'd15, 0, 0);

    // WIDTH=8 instance
    @(negedge clk);
    s8_start = 1'b1; s8_sel = 4'b0001; s8_a = 8'h7F; s8_b = 8'h01;
    @(negedge clk);
    s8_start = 1'b0;
    $display("w8 add 0x7f+1 -> out=0x%0h done=%0b z=%0b", s8_out, s8_done, s8_zero);
    chk("w8 add done", s8_done, 1);
    chk("w8 add out", s8_out, 8'h80);
    chk("w8 add zero", s8_zero, 0);
    @(negedge clk);
    s8_start = 1'b1; s8_sel = 4'b1100; s8_a = 8'h10; s8_b = 8'h11;
    @(negedge clk);
    s8_start = 1'b0;
    seen = 0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      if (s8_done) seen = c;
      else @(negedge clk);
    end
    $display("w8 mul 0x10*0x11 -> out=0x%0h done_cycle=%0d", s8_out, seen);
    chk("w8 mul done cycle", seen, 9);
    chk("w8 mul out", s8_out, 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
